pu_add_cmp_pipe: RTL
====================

Name: pu_add_cmp_pipe

Overview:
Pipelined, parametrised integer ADD/SUB/ADDC/CMP processing unit for the out-of-order back end. It sits in the unique-ack processing-unit chain like the other PUs.
- Accepts one operation per cycle through a valid/ready issue handshake.
- Latches register operands, executes in a second stage, and holds results until writeback accepts them.
- Adds a carry/overflow flag register, add-with-carry, and compare-against-sign-extended-immediate, which earlier units lack.

Parameters:
OPTION_REG_WIDTH, 64, datapath and register width (>=8)
OPTION_OPCODE_WIDTH, 6, opcode field width
OPTION_IMM_WIDTH, 16, immediate width; sign-extended to OPTION_REG_WIDTH

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_valid  in  1  control unit presents an operation
i_opcode  in  OPTION_OPCODE_WIDTH  operation
i_rega  in  5  source A register number
i_regb  in  5  source B register number
i_regd  in  5  destination register number
i_imm  in  OPTION_IMM_WIDTH  immediate for ICMPI
i_cmp_op  in  4  compare condition index (EQ=10, NEQ=1, GTU=2, GTS=3, GEU=4, GES=5, LTU=6, LTS=7, LEU=8, LES=9)
i_unique_ack  in  1  upstream unit already claimed the operation
o_unique_ack  out  1  this unit claims the operation (combinational)
o_ready  out  1  issue stage can accept
o_sela  out  5  = i_rega
o_selb  out  5  = i_regb
i_ina  in  OPTION_REG_WIDTH  register A data (same cycle as select)
i_inb  in  OPTION_REG_WIDTH  register B data
o_write_reg  out  5  writeback destination
o_write_data  out  OPTION_REG_WIDTH  writeback data
o_write_en  out  1  register write request
o_write_flag  out  1  compare-flag write request
o_flag_cmp  out  1  compare result
o_flag_carry  out  1  committed carry flag
o_flag_ov  out  1  committed signed-overflow flag
i_wb_ready  in  1  writeback/flag port accepts this cycle

Behaviour:
- Clocking and reset: single clock i_clk; reset i_rst is synchronous, active-high.
- Opcodes: SUB=1, ADD=2, ICMP=3, ADDC=4, ICMPI=5. Any other opcode is not matched.
- Claim: o_unique_ack = i_valid & !i_unique_ack & match. This is combinational and independent of o_ready; the control unit must hold the operation until accept.
- Accept: accept = o_unique_ack & o_ready.
- Stage S1 (on accept): latch opcode, regd, cmp_op, A=i_ina, and B = sext(i_imm) for ICMPI, else i_inb. Set s1_valid.
- Stage S2 (execute): B' = ~B for SUB/ICMP/ICMPI, else B.
  - cin = 1 for SUB/ICMP/ICMPI; cin = carry_eff for ADDC; else 0.
  - {c, r} = A + B' + cin, computed at OPTION_REG_WIDTH+1 bits.
  - v = (A[msb]==B'[msb]) & (A[msb]^r[msb]).
  - eq = (A==B); lts = r[msb]^v; ltu = !c.
  - Condition map: EQ→eq, NEQ→!eq, GTU→!(eq|ltu), GTS→!(eq|lts), GEU→!ltu, GES→!lts, LTU→ltu, LTS→lts, LEU→ltu|eq, LES→lts|eq. Any other index → 0.
  - Register r, c, v and the condition result into S2.
- Outputs while s2_valid:
  - o_write_en = s2_valid & op∈{ADD, SUB, ADDC}.
  - o_write_flag = s2_valid & op∈{ICMP, ICMPI}.
  - o_write_data, o_write_reg and o_flag_cmp hold S2 contents; all are stable while stalled.
- Commit: when s2_valid & i_wb_ready, the result retires.
  - ADD/SUB/ADDC update carry_q and ov_q.
  - Compares do not touch carry_q or ov_q.
- Carry forwarding: carry_eff = (s2_valid & s2 writes carry) ? s2_c : carry_q.
- Flow control:
  - S2 advances when !s2_valid | i_wb_ready.
  - S1 moves to S2 when s1_valid & S2 advances.
  - o_ready = !s1_valid | S1 moving. This gives full throughput with no bubbles.
- Latency: accept in cycle N → write request visible in cycle N+2 at the earliest.
- Ordering: results retire strictly in issue order.
- Stall: i_wb_ready=0 holds S2. S1 keeps its contents, so one further op may be accepted, then o_ready=0. Nothing is dropped or duplicated.
- Simultaneous events: accept and S1→S2 transfer in the same cycle both occur.
- Wrap: arithmetic is modulo 2^OPTION_REG_WIDTH. Carry is the bit OPTION_REG_WIDTH.
- Reset (also when asserted mid-operation): s1_valid=s2_valid=0 and carry_q=ov_q=0; in-flight ops are discarded. After reset, o_ready=1 and o_write_en=o_write_flag=o_flag_cmp=o_flag_carry=o_flag_ov=0. Data/register outputs reset to 0.

Decomposition:
- Shared package/include pu_defs: opcode constants (SUB, ADD, ICMP, ADDC, ICMPI), FLAG_INDEX_* constants, default widths.
- One sub-module pu_cmp_eval: combinational (A, B', cin, cmp_op) → r, c, v, cmp. It is reusable by future branch units.

Test Plan:
- ADD A=5, B=7, wb_ready=1 → cycle N+2 o_write_en=1, data=12, carry=0 after commit; back-to-back 4 ADDs retire on 4 consecutive cycles.
- SUB 3-5 (64b) → data=0xFFFF_FFFF_FFFF_FFFE, carry=0. ICMP cmp_op=LTU with the same operands → o_write_flag=1, o_flag_cmp=1; the same compare with LTS → 1.
- ADD A=0xFFFF_FFFF_FFFF_FFFF, B=1, immediately followed by ADDC A=0, B=0 → ADD result 0, carry=1; ADDC result 1 via forwarding while ADD is in S2.
- ICMPI A=0xFFFF_FFFF_FFFF_FFFF, imm=16'hFFFF, cmp_op=EQ → flag=1. The same with cmp_op=GTS and A=0 → 1. Overflow: ADD 0x7FFF…F+1 → o_flag_ov=1.
- i_wb_ready=0 for 5 cycles with 3 ops offered → two accepted, o_ready=0, outputs stable; on release the two retire in order, then the third is accepted.
- i_unique_ack=1 or unsupported opcode → o_unique_ack=0, no accept. Reset asserted with both stages full → next cycle no write requests, flags 0, o_ready=1.

Source files
------------

// File: rtl/pu_defs_pkg.sv
// Shared processing-unit definitions: opcodes, compare condition indices, default widths.
package pu_defs_pkg;

  localparam int unsigned DEFAULT_REG_WIDTH    = 64;
  localparam int unsigned DEFAULT_OPCODE_WIDTH = 6;
  localparam int unsigned DEFAULT_IMM_WIDTH    = 16;
  localparam int unsigned REG_SEL_WIDTH        = 5;
  localparam int unsigned CMP_OP_WIDTH         = 4;

  localparam int unsigned OPC_SUB   = 1;
  localparam int unsigned OPC_ADD   = 2;
  localparam int unsigned OPC_ICMP  = 3;
  localparam int unsigned OPC_ADDC  = 4;
  localparam int unsigned OPC_ICMPI = 5;

  localparam logic [CMP_OP_WIDTH-1:0] FLAG_INDEX_EQ  = 4'd10;
  localparam logic [CMP_OP_WIDTH-1:0] FLAG_INDEX_NEQ = 4'd1;
  localparam logic [CMP_OP_WIDTH-1:0] FLAG_INDEX_GTU = 4'd2;
  localparam logic [CMP_OP_WIDTH-1:0] FLAG_INDEX_GTS = 4'd3;
  localparam logic [CMP_OP_WIDTH-1:0] FLAG_INDEX_GEU = 4'd4;
  localparam logic [CMP_OP_WIDTH-1:0] FLAG_INDEX_GES = 4'd5;
  localparam logic [CMP_OP_WIDTH-1:0] FLAG_INDEX_LTU = 4'd6;
  localparam logic [CMP_OP_WIDTH-1:0] FLAG_INDEX_LTS = 4'd7;
  localparam logic [CMP_OP_WIDTH-1:0] FLAG_INDEX_LEU = 4'd8;
  localparam logic [CMP_OP_WIDTH-1:0] FLAG_INDEX_LES = 4'd9;

endpackage

// File: rtl/pu_cmp_eval.sv
// Combinational adder plus condition evaluator: (a, b', cin, cmp_op) -> r, c, v, cmp.
module pu_cmp_eval
  import pu_defs_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_REG_WIDTH
) (
  input  logic [WIDTH-1:0]        a,
  input  logic [WIDTH-1:0]        b,
  input  logic                    cin,
  input  logic [CMP_OP_WIDTH-1:0] cmp_op,
  output logic [WIDTH-1:0]        r,
  output logic                    c,
  output logic                    v,
  output logic                    cmp
);

  logic eq;
  logic lts;
  logic ltu;

  always_comb begin
    {c, r} = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
    v      = (a[WIDTH-1] == b[WIDTH-1]) & (a[WIDTH-1] ^ r[WIDTH-1]);
    // b is the inverted operand with cin=1 for compares, so a zero difference means a == b
    eq     = (r == '0);
    lts    = r[WIDTH-1] ^ v;
    ltu    = ~c;
    cmp    = 1'b0;
    case (cmp_op)
      FLAG_INDEX_EQ:  cmp = eq;
      FLAG_INDEX_NEQ: cmp = ~eq;
      FLAG_INDEX_GTU: cmp = ~(eq | ltu);
      FLAG_INDEX_GTS: cmp = ~(eq | lts);
      FLAG_INDEX_GEU: cmp = ~ltu;
      FLAG_INDEX_GES: cmp = ~lts;
      FLAG_INDEX_LTU: cmp = ltu;
      FLAG_INDEX_LTS: cmp = lts;
      FLAG_INDEX_LEU: cmp = ltu | eq;
      FLAG_INDEX_LES: cmp = lts | eq;
      default:        cmp = 1'b0;
    endcase
  end

endmodule

// File: rtl/pu_add_cmp_pipe.sv
// Two-stage ADD/SUB/ADDC/CMP processing unit with carry/overflow flags and
// writeback backpressure; sits in the unique-ack PU chain.
module pu_add_cmp_pipe
  import pu_defs_pkg::*;
#(
  parameter int unsigned OPTION_REG_WIDTH    = DEFAULT_REG_WIDTH,
  parameter int unsigned OPTION_OPCODE_WIDTH = DEFAULT_OPCODE_WIDTH,
  parameter int unsigned OPTION_IMM_WIDTH    = DEFAULT_IMM_WIDTH
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_valid,
  input  logic [OPTION_OPCODE_WIDTH-1:0] i_opcode,
  input  logic [REG_SEL_WIDTH-1:0]       i_rega,
  input  logic [REG_SEL_WIDTH-1:0]       i_regb,
  input  logic [REG_SEL_WIDTH-1:0]       i_regd,
  input  logic [OPTION_IMM_WIDTH-1:0]    i_imm,
  input  logic [CMP_OP_WIDTH-1:0]        i_cmp_op,
  input  logic                           i_unique_ack,
  output logic                           o_unique_ack,
  output logic                           o_ready,
  output logic [REG_SEL_WIDTH-1:0]       o_sela,
  output logic [REG_SEL_WIDTH-1:0]       o_selb,
  input  logic [OPTION_REG_WIDTH-1:0]    i_ina,
  input  logic [OPTION_REG_WIDTH-1:0]    i_inb,
  output logic [REG_SEL_WIDTH-1:0]       o_write_reg,
  output logic [OPTION_REG_WIDTH-1:0]    o_write_data,
  output logic                           o_write_en,
  output logic                           o_write_flag,
  output logic                           o_flag_cmp,
  output logic                           o_flag_carry,
  output logic                           o_flag_ov,
  input  logic                           i_wb_ready
);

  localparam int unsigned RW = OPTION_REG_WIDTH;
  localparam int unsigned OW = OPTION_OPCODE_WIDTH;

  function automatic logic op_is(input logic [OW-1:0] op, input int unsigned code);
    return op == OW'(code);
  endfunction

  // S1: latched operands
  logic                     s1_valid;
  logic [OW-1:0]            s1_op;
  logic [REG_SEL_WIDTH-1:0] s1_regd;
  logic [CMP_OP_WIDTH-1:0]  s1_cmp_op;
  logic [RW-1:0]            s1_a;
  logic [RW-1:0]            s1_b;

  // S2: executed result awaiting writeback
  logic                     s2_valid;
  logic                     s2_wen;
  logic                     s2_wflag;
  logic [REG_SEL_WIDTH-1:0] s2_reg;
  logic [RW-1:0]            s2_data;
  logic                     s2_c;
  logic                     s2_v;
  logic                     s2_cmp;

  logic carry_q;
  logic ov_q;

  logic          match;
  logic          accept;
  logic          s2_adv;
  logic          s1_move;
  logic          s1_inv;
  logic          s1_arith;
  logic          s1_is_cmp;
  logic          carry_eff;
  logic [RW-1:0] b_eff;
  logic          cin;
  logic [RW-1:0] ex_r;
  logic          ex_c;
  logic          ex_v;
  logic          ex_cmp;

  always_comb begin
    match = op_is(i_opcode, OPC_SUB) | op_is(i_opcode, OPC_ADD) | op_is(i_opcode, OPC_ICMP)
          | op_is(i_opcode, OPC_ADDC) | op_is(i_opcode, OPC_ICMPI);
    o_unique_ack = i_valid & ~i_unique_ack & match;
    s2_adv       = ~s2_valid | i_wb_ready;
    s1_move      = s1_valid & s2_adv;
    o_ready      = ~s1_valid | s1_move;
    accept       = o_unique_ack & o_ready;
    o_sela       = i_rega;
    o_selb       = i_regb;
  end

  // Execute decode; ADDC sees the carry of an arithmetic op still waiting in S2
  always_comb begin
    s1_inv    = op_is(s1_op, OPC_SUB) | op_is(s1_op, OPC_ICMP) | op_is(s1_op, OPC_ICMPI);
    s1_arith  = op_is(s1_op, OPC_SUB) | op_is(s1_op, OPC_ADD) | op_is(s1_op, OPC_ADDC);
    s1_is_cmp = op_is(s1_op, OPC_ICMP) | op_is(s1_op, OPC_ICMPI);
    carry_eff = s2_wen ? s2_c : carry_q;
    b_eff     = s1_inv ? ~s1_b : s1_b;
    cin       = s1_inv | (op_is(s1_op, OPC_ADDC) & carry_eff);
  end

  pu_cmp_eval #(
    .WIDTH (RW)
  ) u_cmp_eval (
    .a      (s1_a),
    .b      (b_eff),
    .cin    (cin),
    .cmp_op (s1_cmp_op),
    .r      (ex_r),
    .c      (ex_c),
    .v      (ex_v),
    .cmp    (ex_cmp)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid  <= 1'b0;
      s1_op     <= '0;
      s1_regd   <= '0;
      s1_cmp_op <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      s2_valid  <= 1'b0;
      s2_wen    <= 1'b0;
      s2_wflag  <= 1'b0;
      s2_reg    <= '0;
      s2_data   <= '0;
      s2_c      <= 1'b0;
      s2_v      <= 1'b0;
      s2_cmp    <= 1'b0;
      carry_q   <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid  <= 1'b1;
        s1_op     <= i_opcode;
        s1_regd   <= i_regd;
        s1_cmp_op <= i_cmp_op;
        s1_a      <= i_ina;
        s1_b      <= op_is(i_opcode, OPC_ICMPI) ? RW'($signed(i_imm)) : i_inb;
      end else if (s1_move) begin
        s1_valid <= 1'b0;
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        s2_wen   <= s1_valid & s1_arith;
        s2_wflag <= s1_valid & s1_is_cmp;
        if (s1_valid) begin
          s2_reg  <= s1_regd;
          s2_data <= ex_r;
          s2_c    <= ex_c;
          s2_v    <= ex_v;
          s2_cmp  <= s1_is_cmp & ex_cmp;
        end
      end
      if (s2_wen && i_wb_ready) begin
        carry_q <= s2_c;
        ov_q    <= s2_v;
      end
    end
  end

  always_comb begin
    o_write_reg  = s2_reg;
    o_write_data = s2_data;
    o_write_en   = s2_wen;
    o_write_flag = s2_wflag;
    o_flag_cmp   = s2_cmp;
    o_flag_carry = carry_q;
    o_flag_ov    = ov_q;
  end

endmodule
